// File: rtl/eth_speed_detect.sv
// Multi-channel RGMII link-speed detector with debounce
// and RX-clock-loss detection, all in the gtx_clk domain.
module eth_speed_detect #(
  parameter int CHANNELS       = 1,
  parameter int REF_CNT_WIDTH  = 7,
  parameter int EDGE_CNT_WIDTH = 2,
  parameter int THRESH_100M    = 32,
  parameter int STABLE_COUNT   = 2,
  parameter int ABSENT_WINDOWS = 4,
  parameter int SYNC_STAGES    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   rx_prescale,
  output logic [2*CHANNELS-1:0] speed,
  output logic [CHANNELS-1:0]   mii_select,
  output logic [CHANNELS-1:0]   clk_present,
  output logic [CHANNELS-1:0]   speed_change
);

  localparam logic [1:0] SPD_10  = 2'b00;
  localparam logic [1:0] SPD_100 = 2'b01;
  localparam logic [1:0] SPD_1G  = 2'b10;

  localparam logic [3:0] STABLE_C = 4'(STABLE_COUNT);
  localparam logic [3:0] ABSENT_C = 4'(ABSENT_WINDOWS);
  localparam logic [REF_CNT_WIDTH-1:0] THRESH_C =
    REF_CNT_WIDTH'(THRESH_100M);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

    logic [SYNC_STAGES-1:0]    sync_q;
    logic [REF_CNT_WIDTH-1:0]  ref_q, ref_d;
    logic [EDGE_CNT_WIDTH-1:0] edg_q, edg_d;
    logic [3:0]                absent_q, absent_d;
    logic [3:0]                agree_q, agree_d;
    logic [1:0]                pend_q, pend_d;
    logic [1:0]                spd_q, spd_d;
    logic                      pres_q, pres_d;
    logic                      chg_q, chg_d;
    logic                      mii_q, mii_d;

    logic       edg_w;
    logic       ref_full;
    logic       edg_full;
    logic       cand_v;
    logic [1:0] cand;
    logic [3:0] absent_inc;

    assign edg_w    = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
    assign ref_full = &ref_q;
    assign edg_full = &edg_q;

    // Bring the asynchronous prescaled RX clock into clk.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_prescale[g]};
    end

    // Window end, classification, presence and debounce.
    always_comb begin
      ref_d      = ref_q + REF_CNT_WIDTH'(1);
      edg_d      = edg_q;
      absent_d   = absent_q;
      agree_d    = agree_q;
      pend_d     = pend_q;
      spd_d      = spd_q;
      pres_d     = pres_q;
      mii_d      = mii_q;
      chg_d      = 1'b0;
      cand_v     = 1'b0;
      cand       = SPD_10;
      absent_inc = (absent_q >= ABSENT_C) ? ABSENT_C
                                          : absent_q + 4'd1;

      // Early end wins over a coincident timeout.
      if (edg_full) begin
        cand_v = 1'b1;
        cand   = (ref_q >= THRESH_C) ? SPD_100 : SPD_1G;
      end else if (ref_full && edg_q != '0) begin
        cand_v = 1'b1;
        cand   = SPD_10;
      end

      // Edges landing on the window-end cycle are dropped.
      if (edg_full || ref_full) begin
        ref_d = '0;
        edg_d = '0;
      end else if (edg_w) begin
        edg_d = edg_q + EDGE_CNT_WIDTH'(1);
      end

      if (cand_v) begin
        pres_d   = 1'b1;
        absent_d = '0;
        pend_d   = cand;
        if (cand == pend_q)
          agree_d = (agree_q >= STABLE_C) ? STABLE_C
                                          : agree_q + 4'd1;
        else
          agree_d = 4'd1;
        if (agree_d >= STABLE_C && cand != spd_q) begin
          spd_d = cand;
          mii_d = (cand != SPD_1G);
          chg_d = 1'b1;
        end
      end else if (ref_full) begin
        absent_d = absent_inc;
        if (absent_inc >= ABSENT_C) begin
          pres_d  = 1'b0;
          pend_d  = SPD_10;
          agree_d = '0;
        end
      end
    end

    // Per-channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ref_q    <= '0;
        edg_q    <= '0;
        absent_q <= '0;
        agree_q  <= '0;
        pend_q   <= SPD_10;
        spd_q    <= SPD_1G;
        pres_q   <= 1'b0;
        chg_q    <= 1'b0;
        mii_q    <= 1'b0;
      end else begin
        ref_q    <= ref_d;
        edg_q    <= edg_d;
        absent_q <= absent_d;
        agree_q  <= agree_d;
        pend_q   <= pend_d;
        spd_q    <= spd_d;
        pres_q   <= pres_d;
        chg_q    <= chg_d;
        mii_q    <= mii_d;
      end
    end

    assign speed[2*g +: 2]  = spd_q;
    assign mii_select[g]    = mii_q;
    assign clk_present[g]   = pres_q;
    assign speed_change[g]  = chg_q;

  end

endmodule

// File: tb/tb_eth_speed_detect.sv
// Bench for eth_speed_detect: two channels driven with
// random toggle rates, checked against rate-class rules.
module tb_eth_speed_detect;

  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] rx = '0;
  logic [2*CH-1:0] speed;
  logic [CH-1:0] mii, pres, chg;

  always #5 clk = ~clk;

  eth_speed_detect #(.CHANNELS(CH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_prescale  (rx),
    .speed        (speed),
    .mii_select   (mii),
    .clk_present  (pres),
    .speed_change (chg)
  );

  int tests = 0;
  int fails = 0;

  int gap  [CH][6];
  int glen [CH];
  int gidx [CH];
  int gcnt [CH];
  int pulses [CH];
  int exp_pul [CH];
  logic [1:0] exp_spd [CH];
  logic       exp_pres [CH];

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_speed"}, 4'(speed), 4'b1010);
    chk({tag, "_mii"},   4'(mii),   4'b0000);
    chk({tag, "_pres"},  4'(pres),  4'b0000);
    chk({tag, "_chg"},   4'(chg),   4'b0000);
  endtask

  // Toggle half-period range that falls squarely in a class.
  function automatic int pick_t(input logic [1:0] cls);
    case (cls)
      2'b10:   return int'($urandom_range(3, 7));
      2'b01:   return int'($urandom_range(17, 40));
      default: return int'($urandom_range(150, 250));
    endcase
  endfunction

  function automatic logic [1:0] rand_cls();
    int r;
    r = int'($urandom_range(0, 2));
    return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_steady(input int c, input int t);
    glen[c]   = 1;
    gap[c][0] = t;
    gidx[c]   = 0;
    gcnt[c]   = 0;
  endtask

  task automatic set_hold(input int c);
    glen[c] = 0;
    gidx[c] = 0;
    gcnt[c] = 0;
  endtask

  // Expected effect of a long stretch at a steady class.
  task automatic model_class(input int c, input logic [1:0] cls);
    exp_pul[c]  = (cls != exp_spd[c]) ? 1 : 0;
    exp_spd[c]  = cls;
    exp_pres[c] = 1'b1;
  endtask

  task automatic model_hold(input int c);
    exp_pul[c]  = 0;
    exp_pres[c] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++)
        if (chg[c] === 1'b1) pulses[c]++;
      if (!rst_n) chk_reset_outs("in_reset");
      for (int c = 0; c < CH; c++) begin
        if (glen[c] > 0) begin
          gcnt[c]++;
          if (gcnt[c] >= gap[c][gidx[c]]) begin
            rx[c]   = ~rx[c];
            gcnt[c] = 0;
            gidx[c] = (gidx[c] + 1) % glen[c];
          end
        end
      end
    end
  endtask

  task automatic check_phase(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s_ch%0d_speed", tag, c),
          4'(speed[2*c +: 2]), 4'(exp_spd[c]));
      chk($sformatf("%s_ch%0d_mii", tag, c),
          4'(mii[c]), 4'(exp_spd[c] != 2'b10));
      chk($sformatf("%s_ch%0d_pres", tag, c),
          4'(pres[c]), 4'(exp_pres[c]));
      chk($sformatf("%s_ch%0d_pulses", tag, c),
          4'(pulses[c]), 4'(exp_pul[c]));
      pulses[c] = 0;
    end
  endtask

  // Ch0 gets a fixed class, ch1 a random one.
  task automatic phase(input string tag, input logic [1:0] cls0);
    logic [1:0] cls1;
    cls1 = rand_cls();
    set_steady(0, pick_t(cls0));
    set_steady(1, pick_t(cls1));
    model_class(0, cls0);
    model_class(1, cls1);
    for (int c = 0; c < CH; c++) pulses[c] = 0;
    run(3000);
    check_phase(tag);
  endtask

  task automatic ch1_random();
    logic [1:0] cls1;
    cls1 = rand_cls();
    set_steady(1, pick_t(cls1));
    model_class(1, cls1);
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      exp_spd[c]  = 2'b10;
      exp_pres[c] = 1'b0;
      exp_pul[c]  = 0;
      pulses[c]   = 0;
      set_steady(c, 4);
    end

    // Toggling under reset must not disturb the outputs.
    rst_n = 1'b0;
    run(30);
    rst_n = 1'b1;
    run(3);
    chk("post_release_speed", 4'(speed), 4'b1010);
    chk("post_release_pres",  4'(pres),  4'b0000);

    phase("p1000", 2'b10);
    phase("p100",  2'b01);
    phase("p10",   2'b00);
    phase("p100b", 2'b01);

    // Loss of clock on ch0 while at 100M.
    set_hold(0);
    model_hold(0);
    ch1_random();
    for (int c = 0; c < CH; c++) pulses[c] = 0;
    run(1500);
    check_phase("loss");

    phase("resume", 2'b10);
    phase("p1000b", 2'b10);

    // Alternating fast/slow windows must never commit.
    glen[0] = 6;
    gidx[0] = 0;
    gcnt[0] = 0;
    for (int k = 0; k < 5; k++) gap[0][k] = 3;
    gap[0][5] = 50;
    model_class(0, 2'b10);
    ch1_random();
    for (int c = 0; c < CH; c++) pulses[c] = 0;
    run(2600);
    check_phase("alternate");

    set_hold(0);
    model_hold(0);
    ch1_random();
    run(1500);
    check_phase("loss2");

    for (int k = 0; k < 4; k++)
      phase($sformatf("rand%0d", k), rand_cls());

    // Reset mid-window takes effect without a clock edge.
    set_steady(0, pick_t(2'b01));
    run(int'($urandom_range(10, 100)));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    for (int c = 0; c < CH; c++) begin
      exp_spd[c]  = 2'b10;
      exp_pres[c] = 1'b0;
    end
    run(20);
    rst_n = 1'b1;
    phase("after_reset", rand_cls());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
